// File: rtl/m_uart_loader.sv
// rtl/m_uart_loader.sv - UART boot loader: 8N1 receiver feeding a framed image into instruction memory
// Frame: A5, word count (16-bit BE), N words MSB-first, 8-bit sum of data bytes.
module m_uart_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_WORDS    = 4096
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        w_rxd,
  output logic        r_we,
  output logic [11:0] r_addr,
  output logic [31:0] r_data,
  output logic        r_busy,
  output logic        r_done,
  output logic        r_err,
  output logic        r_proc_rst
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]   MAX_N = 16'(MAX_WORDS);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_HI = 3'd1;
  localparam logic [2:0] LEN_LO = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] CSUM   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  logic          rxd_s1, rxd_s2, rxd_prev;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_valid;
  logic          rx_ferr;

  // Receiver runs on its own so bytes keep flowing while the FSM is busy writing.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rxd_s1   <= w_rxd;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rxd_prev && !rxd_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_state <= rxd_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == FULL) begin
            rx_cnt   <= '0;
            rx_shift <= {rxd_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_cnt == FULL) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rxd_s2) rx_valid <= 1'b1;
            else        rx_ferr  <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  logic [2:0]  state;
  logic [7:0]  len_hi;
  logic [15:0] n_words;
  logic [12:0] idx;
  logic [15:0] idx_next;
  logic [1:0]  byte_idx;
  logic [23:0] word_hi;
  logic [7:0]  csum;
  logic [15:0] len_rx;

  assign idx_next = {3'b000, idx} + 16'd1;
  assign len_rx   = {len_hi, rx_shift};

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state      <= IDLE;
      len_hi     <= 8'h00;
      n_words    <= 16'h0000;
      idx        <= 13'd0;
      byte_idx   <= 2'd0;
      word_hi    <= 24'h000000;
      csum       <= 8'h00;
      r_we       <= 1'b0;
      r_addr     <= 12'h000;
      r_data     <= 32'h0000_0000;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_proc_rst <= 1'b1;
    end else begin
      r_we <= 1'b0;
      if (rx_ferr && state != DONE && state != ERR) begin
        state  <= ERR;
        r_err  <= 1'b1;
        r_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rx_valid && rx_shift == 8'hA5) begin
              state  <= LEN_HI;
              r_busy <= 1'b1;
            end
          end
          LEN_HI: begin
            if (rx_valid) begin
              len_hi <= rx_shift;
              state  <= LEN_LO;
            end
          end
          LEN_LO: begin
            if (rx_valid) begin
              n_words  <= len_rx;
              idx      <= 13'd0;
              byte_idx <= 2'd0;
              csum     <= 8'h00;
              if (len_rx > MAX_N) begin
                state  <= ERR;
                r_err  <= 1'b1;
                r_busy <= 1'b0;
              end else if (len_rx == 16'h0000) begin
                state <= CSUM;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            // Leave DATA only after the final strobe so r_we stays inside this state.
            if (r_we) begin
              idx <= idx + 13'd1;
              if (idx_next == n_words) state <= CSUM;
            end
            if (rx_valid) begin
              csum     <= csum + rx_shift;
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                r_we   <= 1'b1;
                r_addr <= idx[11:0];
                r_data <= {word_hi, rx_shift};
              end else begin
                word_hi <= {word_hi[15:0], rx_shift};
              end
            end
          end
          CSUM: begin
            if (rx_valid) begin
              r_busy <= 1'b0;
              if (rx_shift == csum) begin
                state      <= DONE;
                r_done     <= 1'b1;
                r_proc_rst <= 1'b0;
              end else begin
                state <= ERR;
                r_err <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_m_uart_loader.sv
// tb/tb_m_uart_loader.sv - scoreboard bench for m_uart_loader at 8 clocks per bit
module tb_m_uart_loader;

  typedef logic [7:0] bq_t[$];

  logic        w_clk = 1'b0;
  logic        w_rst_n = 1'b0;
  logic        w_rxd = 1'b1;
  logic        r_we;
  logic [11:0] r_addr;
  logic [31:0] r_data;
  logic        r_busy, r_done, r_err, r_proc_rst;

  int n_pass = 0;
  int n_total = 0;
  logic [43:0] exp_q[$];

  m_uart_loader #(.CLKS_PER_BIT(8), .MAX_WORDS(4096)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_rxd(w_rxd),
    .r_we(r_we), .r_addr(r_addr), .r_data(r_data),
    .r_busy(r_busy), .r_done(r_done), .r_err(r_err), .r_proc_rst(r_proc_rst)
  );

  always #5 w_clk = ~w_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  always @(negedge w_clk) begin
    if (r_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h required no write", r_addr, r_data);
      end else begin
        logic [43:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", {20'h0, r_addr}, {20'h0, e[43:32]});
        chk("wr_data", r_data, e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    w_rxd = 1'b0;
    repeat (8) @(posedge w_clk);
    for (int i = 0; i < 8; i++) begin
      w_rxd = b[i];
      repeat (8) @(posedge w_clk);
    end
    w_rxd = 1'b1;
    repeat (24) @(posedge w_clk);
  endtask

  task automatic send_stream(input bq_t s);
    foreach (s[i]) send_byte(s[i]);
    repeat (40) @(posedge w_clk);
  endtask

  task automatic do_reset();
    @(negedge w_clk);
    w_rst_n = 1'b0;
    w_rxd   = 1'b1;
    #1;
    chk("rst_addr", {20'h0, r_addr}, 32'h0);
    chk("rst_data", r_data, 32'h0);
    chk("rst_err", {31'h0, r_err}, 32'h0);
    chk("rst_proc_rst", {31'h0, r_proc_rst}, 32'h1);
    repeat (2) @(negedge w_clk);
    w_rst_n = 1'b1;
    repeat (4) @(posedge w_clk);
  endtask

  bq_t good_tail;

  initial begin
    good_tail = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h38};

    // Reset state
    #12;
    chk("init_we", {31'h0, r_we}, 32'h0);
    chk("init_busy", {31'h0, r_busy}, 32'h0);
    chk("init_done", {31'h0, r_done}, 32'h0);
    chk("init_proc_rst", {31'h0, r_proc_rst}, 32'h1);
    @(negedge w_clk);
    w_rst_n = 1'b1;
    repeat (4) @(posedge w_clk);

    // Two-word image, good checksum
    exp_q.push_back({12'h000, 32'h12345678});
    exp_q.push_back({12'h001, 32'h9ABCDEF0});
    send_byte(8'hA5);
    chk("busy_after_sync", {31'h0, r_busy}, 32'h1);
    send_stream(good_tail);
    chk("good_done", {31'h0, r_done}, 32'h1);
    chk("good_proc_rst", {31'h0, r_proc_rst}, 32'h0);
    chk("good_err", {31'h0, r_err}, 32'h0);
    chk("good_busy", {31'h0, r_busy}, 32'h0);
    chk("good_pending", 32'(exp_q.size()), 32'h0);

    // Bad checksum, then a valid stream that must be ignored
    do_reset();
    exp_q.push_back({12'h000, 32'h12345678});
    exp_q.push_back({12'h001, 32'h9ABCDEF0});
    send_stream('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h39});
    chk("badcs_err", {31'h0, r_err}, 32'h1);
    chk("badcs_done", {31'h0, r_done}, 32'h0);
    chk("badcs_proc_rst", {31'h0, r_proc_rst}, 32'h1);
    chk("badcs_pending", 32'(exp_q.size()), 32'h0);
    send_byte(8'hA5);
    send_stream(good_tail);
    chk("err_sticky", {31'h0, r_err}, 32'h1);
    chk("err_no_done", {31'h0, r_done}, 32'h0);

    // Junk before sync, zero-length image
    do_reset();
    send_stream('{8'h00, 8'hFF});
    chk("junk_busy", {31'h0, r_busy}, 32'h0);
    send_stream('{8'hA5, 8'h00, 8'h00, 8'h00});
    chk("zero_done", {31'h0, r_done}, 32'h1);
    chk("zero_proc_rst", {31'h0, r_proc_rst}, 32'h0);

    // Length one beyond capacity
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h01);
    chk("toolong_err", {31'h0, r_err}, 32'h1);
    chk("toolong_busy", {31'h0, r_busy}, 32'h0);
    repeat (20) @(posedge w_clk);

    // Short low glitch between bytes must not produce a byte
    do_reset();
    exp_q.push_back({12'h000, 32'h12345678});
    send_byte(8'hA5);
    w_rxd = 1'b0;
    repeat (2) @(posedge w_clk);
    w_rxd = 1'b1;
    repeat (120) @(posedge w_clk);
    chk("glitch_busy", {31'h0, r_busy}, 32'h1);
    chk("glitch_err", {31'h0, r_err}, 32'h0);
    send_stream('{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14});
    chk("glitch_done", {31'h0, r_done}, 32'h1);
    chk("glitch_pending", 32'(exp_q.size()), 32'h0);

    // Line held low during DATA -> framing error
    do_reset();
    send_stream('{8'hA5, 8'h00, 8'h01, 8'h12});
    w_rxd = 1'b0;
    repeat (96) @(posedge w_clk);
    w_rxd = 1'b1;
    repeat (40) @(posedge w_clk);
    chk("frame_err", {31'h0, r_err}, 32'h1);
    chk("frame_busy", {31'h0, r_busy}, 32'h0);

    // Reset in the middle of the third data byte, then a fresh load
    do_reset();
    send_stream('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34});
    w_rxd = 1'b0;
    repeat (8) @(posedge w_clk);
    for (int i = 0; i < 3; i++) begin
      w_rxd = i[0];
      repeat (8) @(posedge w_clk);
    end
    chk("mid_busy_before", {31'h0, r_busy}, 32'h1);
    @(negedge w_clk);
    w_rst_n = 1'b0;
    w_rxd   = 1'b1;
    #1;
    chk("mid_we", {31'h0, r_we}, 32'h0);
    chk("mid_busy", {31'h0, r_busy}, 32'h0);
    chk("mid_done", {31'h0, r_done}, 32'h0);
    chk("mid_err", {31'h0, r_err}, 32'h0);
    chk("mid_proc_rst", {31'h0, r_proc_rst}, 32'h1);
    chk("mid_addr", {20'h0, r_addr}, 32'h0);
    @(negedge w_clk);
    w_rst_n = 1'b1;
    repeat (100) @(posedge w_clk);
    chk("mid_idle_after", {31'h0, r_busy}, 32'h0);
    exp_q.push_back({12'h000, 32'h12345678});
    exp_q.push_back({12'h001, 32'h9ABCDEF0});
    send_byte(8'hA5);
    send_stream(good_tail);
    chk("reload_done", {31'h0, r_done}, 32'h1);
    chk("reload_pending", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
